probe_frame_sender: RTL and testbench
=====================================

# probe_frame_sender

Parametrised test-frame generator for the delay tester's MAC TX port. It emits bursts of Ethernet frames with configurable length, inter-frame gap and frame count. Each frame carries a sequence number and a transmit timestamp so the receive side can measure per-frame delay. It drives the same byte-wide MAC TX handshake and MAC configuration pins as the existing fixed-ARP sender, and replaces it in the design.

## Interface
Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF: destination address, bytes 0-5, MSB first.
- SRC_MAC, 48'h004e46324300: source address (nf2c0), bytes 6-11.
- ETH_TYPE, 16'h88B5: ethertype, bytes 12-13.
- SEQ_WIDTH, 32: sequence field width in bits; a multiple of 8, 8..64.
- TS_WIDTH, 32: timestamp field width in bits; a multiple of 8, 8..64.
- JUMBO, 0: 1 allows frames up to 9014 bytes and sets conf_tx_jumbo_en.

Ports (single clock; reset is synchronous and active-high):
- tx_clk  in  1  the only clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins a burst when idle.
- stop  in  1  pulse; ends the burst (see Operation).
- frame_len  in  14  frame bytes excluding CRC; sampled at each frame start.
- gap_cycles  in  16  idle cycles between frames; sampled at each frame end.
- frame_count  in  16  frames per burst; 0 means continuous until stop.
- conf_tx_en  out  1  MAC TX enable.
- conf_tx_jumbo_en  out  1  equals JUMBO.
- conf_tx_no_gen_crc  out  1  constant 0; the MAC appends the CRC.
- mac_tx_data  out  8  frame byte.
- mac_tx_dvld  out  1  frame valid.
- mac_tx_ack  in  1  MAC accepted byte 0.
- busy  out  1  high whenever not IDLE.
- frames_sent  out  SEQ_WIDTH  count of completed frames; equals the next sequence number.
- sent_pulse  out  1  one-cycle strobe per completed frame.

## Operation
- Reset values: every output is 0, state is IDLE, and the seq and ts counters are 0.
- conf_tx_en goes to 1 on the first clock after reset is released and stays 1. conf_tx_jumbo_en is registered JUMBO.
- ts: free-running TS_WIDTH counter, +1 every cycle, wraps to 0.
- Length clamp: latched length L = max(60, min(frame_len, JUMBO ? 9014 : 1514)).
- Frame layout, index i:
  - 0-5: DST_MAC.
  - 6-11: SRC_MAC.
  - 12-13: ETH_TYPE.
  - Next SEQ_WIDTH/8 bytes: seq, MSB first.
  - Next TS_WIDTH/8 bytes: ts_cap, MSB first.
  - Remainder: i[7:0].
- ts_cap is the ts value in the cycle mac_tx_ack is sampled high.
- States:
  - IDLE: start && !stop goes to WAIT_ACK. L is latched, byte_idx=0, burst_cnt=0.
  - WAIT_ACK: dvld=1, data=byte 0, held until ack. On ack, go to SEND with byte_idx=1 and capture ts. On stop, go to IDLE; the frame is not counted and seq is unchanged.
  - SEND: one byte per cycle with no backpressure, and ack is ignored. After byte L-1: seq+1, sent_pulse, burst_cnt+1, then go to GAP.
    - stop seen during SEND is remembered; the frame always completes.
  - GAP: dvld=0 for max(gap_cycles,1) cycles. Then:
    - go to IDLE if a stop is pending, or if frame_count!=0 and burst_cnt==frame_count;
    - otherwise go to WAIT_ACK with L re-latched.
- mac_tx_ack outside WAIT_ACK is ignored.
- start while busy is ignored.
- start and stop together in IDLE: stop wins and the block stays in IDLE.
- seq wraps at 2^SEQ_WIDTH. It is cleared only by reset, not by start.

## Timing
- mac_tx_data, mac_tx_dvld and sent_pulse are registered.
- start at cycle N: dvld=1 with byte 0 at cycle N+1.
- ack sampled at cycle M: byte k is driven at M+k for k=1..L-1, and dvld=0 at M+L.
- sent_pulse and the frames_sent increment appear at cycle M+L.
- With gap g, the next frame's dvld rises at M+L+max(g,1).
- Ack in the same cycle dvld first rises: it is valid, and byte 1 follows on the next cycle.
- reset mid-frame: dvld=0 and data=0 in the next cycle, and the block enters IDLE.
- data is 0 whenever dvld=0.

## Test plan
- Reset, then start with frame_len=60, gap=12, count=1, and ack 3 cycles after dvld rises. Required: bytes 0-13 are FF×6, 00 4e 46 32 43 00, 88 B5; bytes 14-17 are 00000000; bytes 18-21 equal ts at the ack cycle; byte 22 is 0x16, up to byte 59 = 0x3B. dvld is high for exactly 3+60 cycles. frames_sent=1 and busy falls.
- count=4, gap=0, ack held high: 4 frames with seq 0..3, each separated by exactly 1 dvld-low cycle, then IDLE.
- frame_len=20 gives 60 bytes. frame_len=2000 with JUMBO=0 gives 1514 bytes. With JUMBO=1, frame_len=9100 gives 9014 bytes and conf_tx_jumbo_en=1.
- count=0 (continuous), stop mid-SEND: the current frame completes and the next dvld stays 0. Repeat with stop during WAIT_ACK: dvld drops next cycle and frames_sent is unchanged.
- reset asserted at byte 30: the next cycle has dvld=0, data=0 and frames_sent=0. Start with simultaneous stop in IDLE: no frame is sent.

Source files
------------

// File: rtl/probe_frame_sender.sv
// Burst test-frame generator for the MAC TX port: each frame carries a sequence
// number and the transmit timestamp so the receiver can measure per-frame delay.
module probe_frame_sender #(
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h004e46324300,
  parameter logic [15:0] ETH_TYPE  = 16'h88B5,
  parameter int          SEQ_WIDTH = 32,
  parameter int          TS_WIDTH  = 32,
  parameter bit          JUMBO     = 1'b0
) (
  input  logic                 tx_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [13:0]          frame_len,
  input  logic [15:0]          gap_cycles,
  input  logic [15:0]          frame_count,
  output logic                 conf_tx_en,
  output logic                 conf_tx_jumbo_en,
  output logic                 conf_tx_no_gen_crc,
  output logic [7:0]           mac_tx_data,
  output logic                 mac_tx_dvld,
  input  logic                 mac_tx_ack,
  output logic                 busy,
  output logic [SEQ_WIDTH-1:0] frames_sent,
  output logic                 sent_pulse
);

  // state    | meaning
  // IDLE     | no burst in progress, waiting for start
  // WAIT_ACK | byte 0 presented, held until the MAC acks it
  // SEND     | streaming bytes 1..L-1, one per cycle
  // GAP      | inter-frame idle countdown
  typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND, GAP} state_t;

  localparam int           SEQ_BYTES = SEQ_WIDTH / 8;
  localparam int           TS_BYTES  = TS_WIDTH / 8;
  localparam int           SEQ_START = 14;
  localparam int           TS_START  = SEQ_START + SEQ_BYTES;
  localparam logic [111:0] HDR       = {DST_MAC, SRC_MAC, ETH_TYPE};
  localparam logic [13:0]  MIN_LEN   = 14'd60;
  localparam logic [13:0]  MAX_LEN   = JUMBO ? 14'd9014 : 14'd1514;

  state_t               state, state_nxt;
  logic [13:0]          len_q, len_nxt, len_clamped;
  logic [13:0]          byte_idx, idx_nxt, byte_sel;
  logic [15:0]          burst_cnt, burst_nxt;
  logic [15:0]          gap_cnt, gap_nxt;
  logic                 stop_pend, pend_nxt;
  logic [SEQ_WIDTH-1:0] seq, seq_nxt;
  logic [TS_WIDTH-1:0]  ts, ts_cap, cap_nxt;
  logic                 dvld_nxt, pulse_nxt;
  logic [7:0]           byte_val;

  assign conf_tx_no_gen_crc = 1'b0;
  assign busy               = (state != IDLE);
  assign frames_sent        = seq;

  always_comb begin
    if (frame_len > MAX_LEN)
      len_clamped = MAX_LEN;
    else if (frame_len < MIN_LEN)
      len_clamped = MIN_LEN;
    else
      len_clamped = frame_len;
  end

  // Payload bytes default to the low byte of their own index.
  always_comb begin
    byte_val = byte_sel[7:0];
    for (int k = 0; k < 14; k++)
      if (byte_sel == 14'(k)) byte_val = HDR[111-8*k -: 8];
    for (int k = 0; k < SEQ_BYTES; k++)
      if (byte_sel == 14'(SEQ_START + k)) byte_val = seq[SEQ_WIDTH-1-8*k -: 8];
    for (int k = 0; k < TS_BYTES; k++)
      if (byte_sel == 14'(TS_START + k)) byte_val = ts_cap[TS_WIDTH-1-8*k -: 8];
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    idx_nxt   = byte_idx;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    pend_nxt  = stop_pend;
    seq_nxt   = seq;
    cap_nxt   = ts_cap;
    dvld_nxt  = 1'b0;
    pulse_nxt = 1'b0;
    byte_sel  = 14'd0;
    case (state)
      IDLE: begin
        pend_nxt = 1'b0;
        if (start && !stop) begin
          state_nxt = WAIT_ACK;
          len_nxt   = len_clamped;
          idx_nxt   = 14'd0;
          burst_nxt = 16'd0;
          dvld_nxt  = 1'b1;
        end
      end
      WAIT_ACK: begin
        dvld_nxt = 1'b1;
        if (stop) begin
          state_nxt = IDLE;
          dvld_nxt  = 1'b0;
        end else if (mac_tx_ack) begin
          state_nxt = SEND;
          idx_nxt   = 14'd1;
          byte_sel  = 14'd1;
          cap_nxt   = ts;
        end
      end
      SEND: begin
        // A stop here only ends the burst after this frame and its gap.
        if (stop) pend_nxt = 1'b1;
        if (byte_idx == len_q - 14'd1) begin
          state_nxt = GAP;
          seq_nxt   = seq + 1'b1;
          pulse_nxt = 1'b1;
          burst_nxt = burst_cnt + 16'd1;
          gap_nxt   = (gap_cycles == 16'd0) ? 16'd1 : gap_cycles;
        end else begin
          idx_nxt  = byte_idx + 14'd1;
          byte_sel = byte_idx + 14'd1;
          dvld_nxt = 1'b1;
        end
      end
      GAP: begin
        if (stop) pend_nxt = 1'b1;
        if (gap_cnt == 16'd1) begin
          if (stop_pend || stop || (frame_count != 16'd0 && burst_cnt == frame_count)) begin
            state_nxt = IDLE;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = WAIT_ACK;
            len_nxt   = len_clamped;
            idx_nxt   = 14'd0;
            dvld_nxt  = 1'b1;
          end
        end else begin
          gap_nxt = gap_cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state            <= IDLE;
      len_q            <= 14'd0;
      byte_idx         <= 14'd0;
      burst_cnt        <= 16'd0;
      gap_cnt          <= 16'd0;
      stop_pend        <= 1'b0;
      seq              <= '0;
      ts               <= '0;
      ts_cap           <= '0;
      mac_tx_dvld      <= 1'b0;
      mac_tx_data      <= 8'h00;
      sent_pulse       <= 1'b0;
      conf_tx_en       <= 1'b0;
      conf_tx_jumbo_en <= 1'b0;
    end else begin
      state            <= state_nxt;
      len_q            <= len_nxt;
      byte_idx         <= idx_nxt;
      burst_cnt        <= burst_nxt;
      gap_cnt          <= gap_nxt;
      stop_pend        <= pend_nxt;
      seq              <= seq_nxt;
      ts               <= ts + 1'b1;
      ts_cap           <= cap_nxt;
      mac_tx_dvld      <= dvld_nxt;
      mac_tx_data      <= dvld_nxt ? byte_val : 8'h00;
      sent_pulse       <= pulse_nxt;
      conf_tx_en       <= 1'b1;
      conf_tx_jumbo_en <= JUMBO;
    end
  end

endmodule

// File: tb/tb_probe_frame_sender.sv
// Self-checking bench for probe_frame_sender: frames are predicted byte by byte
// from the frame layout rules and compared against both a standard and a jumbo instance.
module tb_probe_frame_sender;

  logic        tx_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_j = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] frame_len = 14'd60;
  logic [15:0] gap_cycles = 16'd0;
  logic [15:0] frame_count = 16'd0;
  logic        mac_tx_ack = 1'b0;
  logic        mac_tx_ack_j = 1'b0;

  logic        conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld, busy, sent_pulse;
  logic [31:0] frames_sent;

  logic        conf_tx_en_j, conf_tx_jumbo_en_j, conf_tx_no_gen_crc_j;
  logic [7:0]  mac_tx_data_j;
  logic        mac_tx_dvld_j, busy_j, sent_pulse_j;
  logic [31:0] frames_sent_j;

  probe_frame_sender dut (
    .tx_clk(tx_clk), .reset(reset), .start(start), .stop(stop),
    .frame_len(frame_len), .gap_cycles(gap_cycles), .frame_count(frame_count),
    .conf_tx_en(conf_tx_en), .conf_tx_jumbo_en(conf_tx_jumbo_en),
    .conf_tx_no_gen_crc(conf_tx_no_gen_crc), .mac_tx_data(mac_tx_data),
    .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack), .busy(busy),
    .frames_sent(frames_sent), .sent_pulse(sent_pulse)
  );

  probe_frame_sender #(.JUMBO(1'b1)) dut_j (
    .tx_clk(tx_clk), .reset(reset), .start(start_j), .stop(stop),
    .frame_len(frame_len), .gap_cycles(gap_cycles), .frame_count(frame_count),
    .conf_tx_en(conf_tx_en_j), .conf_tx_jumbo_en(conf_tx_jumbo_en_j),
    .conf_tx_no_gen_crc(conf_tx_no_gen_crc_j), .mac_tx_data(mac_tx_data_j),
    .mac_tx_dvld(mac_tx_dvld_j), .mac_tx_ack(mac_tx_ack_j), .busy(busy_j),
    .frames_sent(frames_sent_j), .sent_pulse(sent_pulse_j)
  );

  always #5 tx_clk = ~tx_clk;

  // Free-running cycle count since reset: the timestamp the frames should carry.
  logic [31:0] tsm = 32'd0;
  always @(posedge tx_clk) begin
    if (reset) tsm <= 32'd0;
    else       tsm <= tsm + 32'd1;
  end

  int          errors = 0;
  int          checks = 0;
  logic        sel_j = 1'b0;
  logic [31:0] exp_seq [2];
  logic [7:0]  frm [0:9013];

  logic        obs_dvld, obs_pulse, obs_busy;
  logic [7:0]  obs_data;
  logic [31:0] obs_sent;
  assign obs_dvld  = sel_j ? mac_tx_dvld_j : mac_tx_dvld;
  assign obs_data  = sel_j ? mac_tx_data_j : mac_tx_data;
  assign obs_pulse = sel_j ? sent_pulse_j : sent_pulse;
  assign obs_busy  = sel_j ? busy_j : busy;
  assign obs_sent  = sel_j ? frames_sent_j : frames_sent;

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic set_ack(input logic v);
    if (sel_j) mac_tx_ack_j = v;
    else       mac_tx_ack = v;
  endtask

  task automatic build_frame(input int len, input logic [31:0] s, input logic [31:0] t);
    logic [111:0] hdr;
    hdr = {48'hFFFFFFFFFFFF, 48'h004e46324300, 16'h88B5};
    for (int k = 0; k < len; k++) begin
      if (k < 14)      frm[k] = 8'(hdr >> (8 * (13 - k)));
      else if (k < 18) frm[k] = 8'(s >> (8 * (17 - k)));
      else if (k < 22) frm[k] = 8'(t >> (8 * (21 - k)));
      else             frm[k] = 8'(k);
    end
  endtask

  // Entered in the first cycle dvld is expected high; returns in the cycle after the last byte.
  task automatic check_frame(input int len, input int ack_delay, input bit hold,
                             input int stop_at, input string name);
    logic [31:0] ts_exp, s;
    int idx;
    idx = sel_j ? 1 : 0;
    s = exp_seq[idx];
    ts_exp = 32'd0;
    for (int d = 0; d <= ack_delay; d++) begin
      if (d == ack_delay) begin
        set_ack(1'b1);
        ts_exp = tsm;
      end
      checks++;
      if (obs_dvld !== 1'b1 || obs_data !== 8'hFF) begin
        errors++;
        $display("FAIL %s wait_ack cycle %0d: got dvld=%b data=%h, want dvld=1 data=ff",
                 name, d, obs_dvld, obs_data);
      end
      tick();
    end
    if (!hold) set_ack(1'b0);
    build_frame(len, s, ts_exp);
    for (int k = 1; k < len; k++) begin
      if (k == stop_at) stop = 1'b1;
      checks++;
      if (obs_dvld !== 1'b1 || obs_data !== frm[k] || obs_pulse !== 1'b0) begin
        errors++;
        $display("FAIL %s byte %0d: got dvld=%b data=%h pulse=%b, want dvld=1 data=%h pulse=0",
                 name, k, obs_dvld, obs_data, obs_pulse, frm[k]);
      end
      tick();
      stop = 1'b0;
    end
    checks++;
    if (obs_dvld !== 1'b0 || obs_data !== 8'h00 || obs_pulse !== 1'b1 || obs_sent !== s + 32'd1) begin
      errors++;
      $display("FAIL %s end: got dvld=%b data=%h pulse=%b sent=%0d, want dvld=0 data=00 pulse=1 sent=%0d",
               name, obs_dvld, obs_data, obs_pulse, obs_sent, s + 32'd1);
    end
    exp_seq[idx] = s + 32'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, mac_tx_dvld, busy, sent_pulse} !== 6'b0 ||
        mac_tx_data !== 8'h00 || frames_sent !== 32'd0 || conf_tx_jumbo_en_j !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got en=%b jumbo=%b nocrc=%b dvld=%b busy=%b pulse=%b data=%h sent=%0d jumbo_j=%b, want all 0",
               conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, mac_tx_dvld, busy, sent_pulse,
               mac_tx_data, frames_sent, conf_tx_jumbo_en_j);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (conf_tx_en !== 1'b1 || conf_tx_jumbo_en !== 1'b0 || conf_tx_no_gen_crc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL conf_after_reset: got en=%b jumbo=%b nocrc=%b busy=%b, want en=1 jumbo=0 nocrc=0 busy=0",
               conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, busy);
    end
    checks++;
    if (conf_tx_en_j !== 1'b1 || conf_tx_jumbo_en_j !== 1'b1 || conf_tx_no_gen_crc_j !== 1'b0) begin
      errors++;
      $display("FAIL conf_jumbo: got en=%b jumbo=%b nocrc=%b, want en=1 jumbo=1 nocrc=0",
               conf_tx_en_j, conf_tx_jumbo_en_j, conf_tx_no_gen_crc_j);
    end
    exp_seq[0] = 32'd0;
    exp_seq[1] = 32'd0;
  endtask

  task automatic test_single_frame();
    sel_j = 1'b0;
    frame_len = 14'd60;
    gap_cycles = 16'd12;
    frame_count = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(60, 3, 1'b0, -1, "single");
    for (int g = 0; g < 12; g++) begin
      if (g == 4) start = 1'b1;
      checks++;
      if (mac_tx_dvld !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_gap %0d: got dvld=%b busy=%b, want dvld=0 busy=1", g, mac_tx_dvld, busy);
      end
      tick();
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || mac_tx_dvld !== 1'b0 || frames_sent !== 32'd1) begin
      errors++;
      $display("FAIL single_done: got busy=%b dvld=%b sent=%0d, want busy=0 dvld=0 sent=1",
               busy, mac_tx_dvld, frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    sel_j = 1'b0;
    len = $urandom_range(60, 120);
    frame_len = 14'(len);
    gap_cycles = 16'd0;
    frame_count = 16'd4;
    mac_tx_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      check_frame(len, 0, 1'b1, -1, "b2b");
      tick();
    end
    mac_tx_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || mac_tx_dvld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got busy=%b dvld=%b, want busy=0 dvld=0", busy, mac_tx_dvld);
    end
  endtask

  task automatic test_len_clamp();
    int  lens [8];
    int  exps [8];
    bit  js [8];
    lens = '{20, 2000, 9100, 0, 60, 1514, 9100, 20};
    exps = '{60, 1514, 1514, 0, 60, 1514, 9014, 60};
    js   = '{0, 0, 0, 0, 0, 0, 1, 1};
    lens[3] = $urandom_range(61, 1513);
    exps[3] = lens[3];
    frame_count = 16'd1;
    gap_cycles = 16'd1;
    for (int i = 0; i < 8; i++) begin
      sel_j = js[i];
      frame_len = 14'(lens[i]);
      if (js[i]) start_j = 1'b1;
      else       start = 1'b1;
      tick();
      start = 1'b0;
      start_j = 1'b0;
      check_frame(exps[i], $urandom_range(0, 4), 1'b0, -1, "len_clamp");
      tick();
      checks++;
      if (obs_busy !== 1'b0 || obs_dvld !== 1'b0) begin
        errors++;
        $display("FAIL len_clamp_idle %0d: got busy=%b dvld=%b, want busy=0 dvld=0", i, obs_busy, obs_dvld);
      end
    end
    sel_j = 1'b0;
  endtask

  task automatic test_stop_send();
    int len, g, k;
    sel_j = 1'b0;
    frame_count = 16'd0;
    g = $urandom_range(2, 6);
    gap_cycles = 16'(g);
    len = $urandom_range(60, 90);
    frame_len = 14'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(len, $urandom_range(0, 3), 1'b0, -1, "cont_first");
    for (int i = 0; i < g; i++) begin
      checks++;
      if (mac_tx_dvld !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL cont_gap %0d: got dvld=%b busy=%b, want dvld=0 busy=1", i, mac_tx_dvld, busy);
      end
      tick();
    end
    k = $urandom_range(1, len - 1);
    check_frame(len, $urandom_range(0, 3), 1'b0, k, "stop_send");
    for (int i = 0; i < g + 4; i++) begin
      checks++;
      if (mac_tx_dvld !== 1'b0 || busy !== (i < g)) begin
        errors++;
        $display("FAIL stop_send_after %0d: got dvld=%b busy=%b, want dvld=0 busy=%b",
                 i, mac_tx_dvld, busy, (i < g));
      end
      tick();
    end
    checks++;
    if (frames_sent !== exp_seq[0]) begin
      errors++;
      $display("FAIL stop_send_count: got %0d, want %0d", frames_sent, exp_seq[0]);
    end
  endtask

  task automatic test_stop_wait();
    sel_j = 1'b0;
    frame_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stop = 1'b1;
      checks++;
      if (mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'hFF) begin
        errors++;
        $display("FAIL stop_wait_hold %0d: got dvld=%b data=%h, want dvld=1 data=ff", i, mac_tx_dvld, mac_tx_data);
      end
      tick();
      stop = 1'b0;
    end
    checks++;
    if (mac_tx_dvld !== 1'b0 || mac_tx_data !== 8'h00 || busy !== 1'b0 || frames_sent !== exp_seq[0]) begin
      errors++;
      $display("FAIL stop_wait_drop: got dvld=%b data=%h busy=%b sent=%0d, want dvld=0 data=00 busy=0 sent=%0d",
               mac_tx_dvld, mac_tx_data, busy, frames_sent, exp_seq[0]);
    end
    repeat (3) begin
      tick();
      checks++;
      if (mac_tx_dvld !== 1'b0) begin
        errors++;
        $display("FAIL stop_wait_quiet: got dvld=%b, want 0", mac_tx_dvld);
      end
    end
  endtask

  task automatic test_start_stop();
    sel_j = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b0 || mac_tx_dvld !== 1'b0 || frames_sent !== exp_seq[0]) begin
        errors++;
        $display("FAIL start_stop %0d: got busy=%b dvld=%b sent=%0d, want busy=0 dvld=0 sent=%0d",
                 i, busy, mac_tx_dvld, frames_sent, exp_seq[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    sel_j = 1'b0;
    frame_count = 16'd0;
    frame_len = 14'd80;
    gap_cycles = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    mac_tx_ack = 1'b1;
    tick();
    mac_tx_ack = 1'b0;
    checks++;
    if (mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'hFF) begin
      errors++;
      $display("FAIL ack_first_cycle: got dvld=%b data=%h, want dvld=1 data=ff (byte 1)", mac_tx_dvld, mac_tx_data);
    end
    repeat (29) tick();
    checks++;
    if (mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'd30) begin
      errors++;
      $display("FAIL byte30: got dvld=%b data=%h, want dvld=1 data=1e", mac_tx_dvld, mac_tx_data);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mac_tx_dvld !== 1'b0 || mac_tx_data !== 8'h00 || frames_sent !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got dvld=%b data=%h sent=%0d busy=%b, want dvld=0 data=00 sent=0 busy=0",
               mac_tx_dvld, mac_tx_data, frames_sent, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mac_tx_dvld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got busy=%b dvld=%b, want busy=0 dvld=0", busy, mac_tx_dvld);
    end
    exp_seq[0] = 32'd0;
    exp_seq[1] = 32'd0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_len_clamp();
    test_stop_send();
    test_stop_wait();
    test_start_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
